// File: rtl/pipe_dff_chain_pkg.sv
// Shared ALU constants: multiplier product width and the default depth of the
// register chains placed inside the multiplier.
package pipe_dff_chain_pkg;

  localparam int PRODUCT_W  = 64;
  localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/pipe_dff_chain_stage.sv
// One valid/data slot of the register chain. An empty slot always accepts, so
// a stall only holds the slots that actually carry words.
module pipe_dff_stage
  import pipe_dff_chain_pkg::*;
#(
  parameter int                 WIDTH     = PRODUCT_W,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic             valid_next,
  output logic [WIDTH-1:0] q
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  assign ready = ~valid_r | down_ready;
  assign valid = valid_r;
  assign q     = data_r;

  always_comb begin
    valid_next = valid_r;
    if (flush) begin
      valid_next = 1'b0;
    end else if (ready) begin
      valid_next = up_valid;
    end
  end

  // Flush clears the valid bit only; the data register never loads during it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= RESET_VAL;
    end else begin
      valid_r <= valid_next;
      if (!flush && ready && up_valid) begin
        data_r <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_dff_chain.sv
// DEPTH-stage register chain with valid/ready backpressure, bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_dff_chain
  import pipe_dff_chain_pkg::*;
#(
  parameter int               WIDTH     = PRODUCT_W,
  parameter int               DEPTH     = PIPE_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_dff_chain: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_dff_chain: WIDTH must be >= 1");
  end

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCC_W'(vec[i]);
    end
    return cnt;
  endfunction

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [WIDTH-1:0] d    [DEPTH];
  logic [OCC_W-1:0] occ_r;

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] & ~flush;
  assign out_valid  = v[DEPTH-1];
  assign q          = d[DEPTH-1];
  assign occupancy  = occ_r;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_v[i] = in_valid & ~flush;
      assign up_d[i] = data;
    end else begin : g_body
      assign up_v[i] = v[i-1];
      assign up_d[i] = d[i-1];
    end

    pipe_dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid   (up_v[i]),
      .up_data    (up_d[i]),
      .down_ready (rdy[i+1]),
      .ready      (rdy[i]),
      .valid      (v[i]),
      .valid_next (v_next[i]),
      .q          (d[i])
    );
  end

  // Count the next-state valid bits so occupancy lands on the same edge as v.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r <= '0;
    end else begin
      occ_r <= popcount(v_next);
    end
  end

endmodule

// File: tb/tb_pipe_dff_chain.sv
// Directed bench for pipe_dff_chain: a cycle table on a 64x3 chain plus a
// hand sequence for bubble collapsing on an 8x4 chain.
module tb_pipe_dff_chain;

  localparam logic [63:0] RV_A = 64'hA5A5A5A5A5A5A5A5;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [63:0] a_data, a_q;
  logic [1:0]  a_occ;

  logic        b_reset, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [7:0]  b_data, b_q;
  logic [2:0]  b_occ;

  pipe_dff_chain #(.WIDTH(64), .DEPTH(3), .RESET_VAL(RV_A)) dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data(a_data), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .q(a_q), .occupancy(a_occ)
  );

  pipe_dff_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data(b_data), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .q(b_q), .occupancy(b_occ)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs for the cycle plus the outputs expected during that cycle
  // (i.e. the state left by earlier edges, and the combinational in_ready).
  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [63:0] dat;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_q;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic ordy, input logic [63:0] dat,
                              input logic e_ir, input logic e_ov,
                              input logic [63:0] e_q, input logic [1:0] e_occ);
    vec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.ordy = ordy; r.dat = dat;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_q = e_q; r.e_occ = e_occ;
    return r;
  endfunction

  task automatic b_step(input string nm, input logic iv, input logic [7:0] d,
                        input logic ordy, input logic e_ir, input logic e_ov,
                        input logic [7:0] e_q, input logic [2:0] e_occ);
    b_in_valid  = iv;
    b_data      = d;
    b_out_ready = ordy;
    @(negedge clk);
    chk({nm, ".in_ready"},  64'(b_in_ready),  64'(e_ir));
    chk({nm, ".out_valid"}, 64'(b_out_valid), 64'(e_ov));
    chk({nm, ".q"},         64'(b_q),         64'(e_q));
    chk({nm, ".occ"},       64'(b_occ),       64'(e_occ));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    //        rst fl iv or data                 ir ov q                    occ
    // streaming, out_ready=1
    tbl.push_back(mk(0, 0, 1, 1, 64'h8484848484848484, 1, 0, RV_A,                 0));
    tbl.push_back(mk(0, 0, 1, 1, 64'h4848484848484848, 1, 0, RV_A,                 1));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 0, RV_A,                 2));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 1, 64'h8484848484848484, 2));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 1, 64'h4848484848484848, 1));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 0, 64'h4848484848484848, 0));
    // full stall: 1,2,3 accepted, 4 refused while out_ready=0
    tbl.push_back(mk(0, 0, 1, 0, 64'h1,                1, 0, 64'h4848484848484848, 0));
    tbl.push_back(mk(0, 0, 1, 0, 64'h2,                1, 0, 64'h4848484848484848, 1));
    tbl.push_back(mk(0, 0, 1, 0, 64'h3,                1, 0, 64'h4848484848484848, 2));
    tbl.push_back(mk(0, 0, 1, 0, 64'h4,                0, 1, 64'h1,                3));
    tbl.push_back(mk(0, 0, 1, 0, 64'h4,                0, 1, 64'h1,                3));
    // pop and push while full
    tbl.push_back(mk(0, 0, 1, 1, 64'h4,                1, 1, 64'h1,                3));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,                0, 1, 64'h2,                3));
    // drain in order
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 1, 64'h2,                3));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 1, 64'h3,                2));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 1, 64'h4,                1));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 0, 64'h4,                0));
    // flush with two words in flight and DEAD presented
    tbl.push_back(mk(0, 0, 1, 0, 64'h10,               1, 0, 64'h4,                0));
    tbl.push_back(mk(0, 0, 1, 0, 64'h20,               1, 0, 64'h4,                1));
    tbl.push_back(mk(0, 1, 1, 1, 64'hDEAD,             0, 0, 64'h4,                2));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 0, 64'h4,                0));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 0, 64'h4,                0));
    tbl.push_back(mk(0, 0, 0, 1, 64'h0,                1, 0, 64'h4,                0));
    // reset with a full chain, together with flush and in_valid
    tbl.push_back(mk(0, 0, 1, 0, 64'h31,               1, 0, 64'h4,                0));
    tbl.push_back(mk(0, 0, 1, 0, 64'h32,               1, 0, 64'h4,                1));
    tbl.push_back(mk(0, 0, 1, 0, 64'h33,               1, 0, 64'h4,                2));
    tbl.push_back(mk(1, 1, 1, 0, 64'h34,               0, 1, 64'h31,               3));
    tbl.push_back(mk(0, 0, 0, 0, 64'h0,                1, 0, RV_A,                 0));

    a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_data = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_data = '0;
    @(posedge clk);
    #1;
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);
    chk("reset.a.in_ready",  64'(a_in_ready),  64'(1));
    chk("reset.a.out_valid", 64'(a_out_valid), 64'(0));
    chk("reset.a.q",         a_q,              RV_A);
    chk("reset.a.occ",       64'(a_occ),       64'(0));
    chk("reset.b.q",         64'(b_q),         64'(0));
    chk("reset.b.occ",       64'(b_occ),       64'(0));
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      a_reset     = tbl[i].rst;
      a_flush     = tbl[i].fl;
      a_in_valid  = tbl[i].iv;
      a_out_ready = tbl[i].ordy;
      a_data      = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("row%0d.in_ready", i),  64'(a_in_ready),  64'(tbl[i].e_ir));
      chk($sformatf("row%0d.out_valid", i), 64'(a_out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("row%0d.q", i),         a_q,              tbl[i].e_q);
      chk($sformatf("row%0d.occ", i),       64'(a_occ),       64'(tbl[i].e_occ));
      @(posedge clk);
      #1;
    end

    // Bubble collapse on the 8x4 chain: 11, two idle cycles, 22, under stall.
    b_step("bub1", 1, 8'h11, 0, 1, 0, 8'h00, 0);
    b_step("bub2", 0, 8'h00, 0, 1, 0, 8'h00, 1);
    b_step("bub3", 0, 8'h00, 0, 1, 0, 8'h00, 1);
    b_step("bub4", 1, 8'h22, 0, 1, 0, 8'h00, 1);
    b_step("bub5", 0, 8'h00, 0, 1, 1, 8'h11, 2);
    b_step("bub6", 0, 8'h00, 0, 1, 1, 8'h11, 2);
    b_step("bub7", 0, 8'h00, 0, 1, 1, 8'h11, 2);
    b_step("bub8", 0, 8'h00, 1, 1, 1, 8'h11, 2);
    b_step("bub9", 0, 8'h00, 1, 1, 1, 8'h22, 1);
    b_step("bub10", 0, 8'h00, 1, 1, 0, 8'h22, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
